// File: rtl/delay_tap_scheduler.sv
// delay_tap_scheduler
//   Sequences a shared single-port sample memory for a delay/reverb path.
//   Each ADC sample strobe optionally writes the sample into a circular
//   buffer, reads up to MAX_TAPS delayed taps with geometric gain decay,
//   and emits one saturated dry+wet output sample.
//
//   Ports
//     clk, rstb                 clock, asynchronous active-low reset
//     sample_valid, sample_in   ADC sample strobe and signed sample
//     record, loop              buffer write enable / replay (loop wins)
//     delay_reverb, delay_len,
//     impulses, gain            per-sample configuration (sampled at strobe)
//     mem_req/we/addr/wdata     memory request port
//     mem_ready, mem_rdata      memory completion and read data
//     out_valid, out_sample     output strobe and saturated sample
//     busy, overrun             sequence active / sticky dropped-sample flag
//     mem_timeout               sticky watchdog flag
//
//   Build option: define MEM_TIMEOUT_EN to enable the memory watchdog.
//   Without it the sequencer waits indefinitely and mem_timeout stays 0.

module delay_tap_scheduler #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned MAX_TAPS = 8
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              record,
   input  logic              loop,
   input  logic              delay_reverb,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic [7:0]        impulses,
   input  logic [7:0]        gain,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_sample,
   output logic              busy,
   output logic              overrun,
   output logic              mem_timeout
);

   localparam int unsigned ACC_W  = DATA_W + 4;
   localparam int unsigned TAP_W  = $clog2(MAX_TAPS + 1);
   localparam int unsigned PROD_W = DATA_W + 9;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_GAP   = 3'd3,
      ST_MIX   = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [7:0]               g_q, g_d;
   logic [7:0]               gain_q, gain_d;
   logic [ADDR_W-1:0]        delay_q, delay_d;
   logic [TAP_W-1:0]         taps_q, taps_d;
   logic [TAP_W-1:0]         k_q, k_d;
   logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;

   logic                     mem_req_d, mem_we_d;
   logic [ADDR_W-1:0]        mem_addr_d;
   logic [DATA_W-1:0]        mem_wdata_d;
   logic                     out_valid_d;
   logic [DATA_W-1:0]        out_sample_d;
   logic                     busy_d, overrun_d, mem_timeout_d;

   logic                     abort_c;
   logic                     done_c;
   logic signed [DATA_W-1:0] rdata_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  wet_c;
   logic [15:0]              gprod_c;
   logic [TAP_W-1:0]         taps_c;
   logic [ADDR_W-1:0]        first_addr_c;
   logic [DATA_W-1:0]        sat_c;

`ifdef MEM_TIMEOUT_EN
   // Watchdog: counts stalled request cycles, aborts the transfer at 255
   logic [7:0] wd_q, wd_d;

   always_comb begin
      wd_d    = 8'd0;
      abort_c = mem_req && !mem_ready && (wd_q == 8'hFF);
      if (mem_req && !mem_ready && !abort_c) begin
         wd_d = wd_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) wd_q <= 8'd0;
      else       wd_q <= wd_d;
   end
`else
   assign abort_c = 1'b0;
`endif

   // Transfer completion; an aborted read contributes zero
   assign done_c  = mem_req && (mem_ready || abort_c);
   assign rdata_c = mem_ready ? $signed(mem_rdata) : '0;

   // Tap contribution (rdata * g) >>> 8 and next geometric gain
   assign prod_c  = $signed(PROD_W'(rdata_c)) * $signed(PROD_W'({1'b0, g_q}));
   assign wet_c   = ACC_W'(prod_c >>> 8);
   assign gprod_c = 16'(g_q) * 16'(gain_q);

   // Tap count for a new sample; zero spacing disables all taps
   always_comb begin
      taps_c = TAP_W'(1);
      if (delay_reverb) begin
         taps_c = (impulses > 8'(MAX_TAPS)) ? TAP_W'(MAX_TAPS) : TAP_W'(impulses);
      end
      if (delay_len == '0) begin
         taps_c = '0;
      end
   end

   assign first_addr_c = wr_ptr_q - delay_len;

   // Output saturation
   always_comb begin
      sat_c = DATA_W'(acc_q);
      if (acc_q > SAT_MAX)      sat_c = DATA_W'(SAT_MAX);
      else if (acc_q < SAT_MIN) sat_c = DATA_W'(SAT_MIN);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      g_d           = g_q;
      gain_d        = gain_q;
      delay_d       = delay_q;
      taps_d        = taps_q;
      k_d           = k_q;
      rd_addr_d     = rd_addr_q;
      wr_ptr_d      = wr_ptr_q;
      mem_req_d     = mem_req;
      mem_we_d      = mem_we;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      out_valid_d   = 1'b0;
      out_sample_d  = out_sample;
      overrun_d     = overrun;
      mem_timeout_d = mem_timeout | abort_c;

      case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               acc_d     = ACC_W'($signed(sample_in));
               g_d       = gain;
               gain_d    = gain;
               delay_d   = delay_len;
               taps_d    = taps_c;
               k_d       = '0;
               rd_addr_d = first_addr_c;
               if (record && !loop) begin
                  state_d     = ST_WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_ptr_q;
                  mem_wdata_d = sample_in;
               end else if (taps_c != '0) begin
                  state_d    = ST_READ;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = first_addr_c;
                  rd_addr_d  = first_addr_c - delay_len;
               end else begin
                  state_d = ST_MIX;
               end
            end
         end
         ST_WRITE: begin
            if (done_c) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = ST_GAP;
            end
         end
         ST_READ: begin
            if (done_c) begin
               acc_d     = acc_q + wet_c;
               g_d       = 8'(gprod_c >> 8);
               k_d       = k_q + TAP_W'(1);
               mem_req_d = 1'b0;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            // One idle cycle between transfers, then next tap or mix
            if (k_q < taps_q) begin
               state_d    = ST_READ;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = rd_addr_q;
               rd_addr_d  = rd_addr_q - delay_q;
            end else begin
               state_d = ST_MIX;
            end
         end
         ST_MIX: begin
            out_valid_d  = 1'b1;
            out_sample_d = sat_c;
            wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (sample_valid && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         g_q         <= '0;
         gain_q      <= '0;
         delay_q     <= '0;
         taps_q      <= '0;
         k_q         <= '0;
         rd_addr_q   <= '0;
         wr_ptr_q    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         out_valid   <= 1'b0;
         out_sample  <= '0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         g_q         <= g_d;
         gain_q      <= gain_d;
         delay_q     <= delay_d;
         taps_q      <= taps_d;
         k_q         <= k_d;
         rd_addr_q   <= rd_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         out_valid   <= out_valid_d;
         out_sample  <= out_sample_d;
         busy        <= busy_d;
         overrun     <= overrun_d;
         mem_timeout <= mem_timeout_d;
      end
   end

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// tb_delay_tap_scheduler
//   Self-checking bench for delay_tap_scheduler: a behavioural memory, a
//   transaction scoreboard and a sample-level reference model computed
//   directly from the tap/gain/saturation rules.

module tb_delay_tap_scheduler;

   logic        clk;
   logic        rstb;
   logic        sample_valid;
   logic [15:0] sample_in;
   logic        record;
   logic        loop;
   logic        delay_reverb;
   logic [15:0] delay_len;
   logic [7:0]  impulses;
   logic [7:0]  gain;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic [15:0] out_sample;
   logic        busy;
   logic        overrun;
   logic        mem_timeout;

   delay_tap_scheduler dut (
      .clk          (clk),
      .rstb         (rstb),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .record       (record),
      .loop         (loop),
      .delay_reverb (delay_reverb),
      .delay_len    (delay_len),
      .impulses     (impulses),
      .gain         (gain),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_sample   (out_sample),
      .busy         (busy),
      .overrun      (overrun),
      .mem_timeout  (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } txn_t;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   txn_t        exp_q[$];
   logic [15:0] wp;
   int          ready_mode;
   int          n_out;
   int          n_total;
   int          n_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Memory: ready policy, read data and transaction scoreboard
   initial begin
      txn_t e;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 2) != 0);
            default: mem_ready = 1'b0;
         endcase
         mem_rdata = mem[mem_addr];
         if (rstb && mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
               check("txn_extra", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("txn_we", 32'(mem_we), 32'(e.we));
               check("txn_addr", 32'(mem_addr), 32'(e.addr));
               if (e.we) check("txn_wdata", 32'(mem_wdata), 32'(e.data));
            end
            if (mem_we) mem[mem_addr] = mem_wdata;
         end
      end
   end

   initial begin
      n_out = 0;
      forever begin
         @(negedge clk);
         if (out_valid) n_out++;
      end
   end

   // Reference: expected transfers and output for one accepted sample
   task automatic model_sample(input logic [15:0] s, input bit rec, input bit lp, input bit dr,
                               input logic [15:0] dl, input logic [7:0] imp, input logic [7:0] gn,
                               output logic [15:0] exp_out, output int n_xfer);
      int acc, r, g, t;
      logic [15:0] a;
      t = dr ? ((imp > 8'd8) ? 8 : int'(imp)) : 1;
      if (dl == 16'd0) t = 0;
      n_xfer = t;
      if (rec && !lp) begin
         exp_q.push_back('{1'b1, wp, s});
         ref_mem[wp] = s;
         n_xfer++;
      end
      acc = int'($signed(s));
      g   = int'(gn);
      for (int k = 1; k <= t; k++) begin
         a = wp - 16'(k) * dl;
         exp_q.push_back('{1'b0, a, 16'd0});
         r   = int'($signed(ref_mem[a]));
         acc = acc + ((r * g) >>> 8);
         g   = (g * int'(gn)) >> 8;
      end
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      exp_out = 16'(acc);
      wp = wp + 16'd1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstb = 1'b0;
      sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      wp = 16'd0;
      exp_q.delete();
   endtask

   // Issue one sample, wait for its output and compare against the model
   task automatic do_sample(input logic [15:0] s, input bit rec, input bit lp, input bit dr,
                            input logic [15:0] dl, input logic [7:0] imp, input logic [7:0] gn,
                            input int mode, input bit scramble, output logic [15:0] got_val);
      logic [15:0] exp_out;
      int n, lat;
      bit got;
      model_sample(s, rec, lp, dr, dl, imp, gn, exp_out, n);
      @(negedge clk);
      ready_mode   = mode;
      sample_in    = s;
      record       = rec;
      loop         = lp;
      delay_reverb = dr;
      delay_len    = dl;
      impulses     = imp;
      gain         = gn;
      sample_valid = 1'b1;
      lat = 0;
      got = 1'b0;
      got_val = '0;
      while (!got && lat < 3000) begin
         @(negedge clk);
         sample_valid = 1'b0;
         lat++;
         if (out_valid) begin
            got = 1'b1;
            got_val = out_sample;
         end
         if (scramble) begin
            sample_in    = 16'($urandom);
            record       = 1'($urandom);
            loop         = 1'($urandom);
            delay_reverb = 1'($urandom);
            delay_len    = 16'($urandom);
            impulses     = 8'($urandom);
            gain         = 8'($urandom);
         end
      end
      check("out_seen", 32'(got), 32'd1);
      if (got) begin
         check("out_sample", 32'(got_val), 32'(exp_out));
         check("busy_end", 32'(busy), 32'd0);
         if (mode == 0) check("latency", 32'(lat), 32'(2 + 2 * n));
      end
      check("txn_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] v, exp_out;
      int n, n0, cyc;
      n_total = 0;
      n_bad   = 0;
      ready_mode = 0;
      rstb = 1'b0;
      sample_valid = 1'b0;
      sample_in = '0;
      record = 1'b0;
      loop = 1'b0;
      delay_reverb = 1'b0;
      delay_len = '0;
      impulses = '0;
      gain = '0;
      wp = 16'd0;
      for (int i = 0; i < 65536; i++) preload(16'(i), 16'($urandom));

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sample", 32'(out_sample), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_mem_timeout", 32'(mem_timeout), 32'd0);
      rstb = 1'b1;

      // Record with no taps: write addr 0, dry output
      do_sample(16'd100, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 8'd128, 0, 1'b0, v);
      check("t1_out", 32'(v), 32'd100);
      check("t1_mem", 32'(mem[0]), 32'd100);

      // Advance pointer to 4 without writing, then a single delay tap
      for (int i = 0; i < 3; i++) do_sample(16'd7, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 0, 1'b0, v);
      preload(16'd0, 16'd1000);
      do_sample(16'd0, 1'b1, 1'b0, 1'b0, 16'd4, 8'd0, 8'd128, 0, 1'b0, v);
      check("t2_out", 32'(v), 32'd500);

      // Reverb, three taps wrapping below address 0
      do_reset();
      do_sample(16'd1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 0, 1'b0, v);
      preload(16'hFFFF, 16'd1024);
      preload(16'hFFFD, 16'd1024);
      preload(16'hFFFB, 16'd1024);
      do_sample(16'd50, 1'b0, 1'b0, 1'b1, 16'd2, 8'd3, 8'd128, 0, 1'b0, v);
      check("t3_out", 32'(v), 32'd946);

      // Positive and negative saturation
      preload(wp - 16'd1, 16'd32000);
      do_sample(16'd32000, 1'b0, 1'b0, 1'b0, 16'd1, 8'd0, 8'd255, 0, 1'b0, v);
      check("t4_sat_pos", 32'(v), 32'h7FFF);
      preload(wp - 16'd1, 16'h8300);
      do_sample(16'h8300, 1'b0, 1'b0, 1'b0, 16'd1, 8'd0, 8'd255, 0, 1'b0, v);
      check("t4_sat_neg", 32'(v), 32'h8000);

      // Sample strobe while busy: dropped, overrun sticky, one output
      check("t5_overrun_pre", 32'(overrun), 32'd0);
      model_sample(16'd300, 1'b1, 1'b0, 1'b0, 16'd3, 8'd0, 8'd200, exp_out, n);
      n0 = n_out;
      @(negedge clk);
      ready_mode = 2;
      sample_in = 16'd300; record = 1'b1; loop = 1'b0; delay_reverb = 1'b0;
      delay_len = 16'd3; gain = 8'd200; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      sample_in = 16'd999;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (5) @(negedge clk);
      ready_mode = 0;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_out_seen", 32'(out_valid), 32'd1);
      check("t5_out", 32'(out_sample), 32'(exp_out));
      check("t5_overrun", 32'(overrun), 32'd1);
      repeat (10) @(negedge clk);
      check("t5_one_out", 32'(n_out - n0), 32'd1);
      check("t5_txn_left", 32'(exp_q.size()), 32'd0);

      // Reset during a stalled transfer: request drops at once, no output
      @(negedge clk);
      ready_mode = 2;
      record = 1'b1; loop = 1'b0; sample_in = 16'd55; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mid_req_pre", 32'(mem_req), 32'd1);
      #2 rstb = 1'b0;
      #1;
      check("rst_mid_req", 32'(mem_req), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      n0 = n_out;
      @(negedge clk);
      rstb = 1'b1;
      ready_mode = 0;
      wp = 16'd0;
      exp_q.delete();
      repeat (10) @(negedge clk);
      check("rst_mid_no_out", 32'(n_out - n0), 32'd0);
      check("rst_mid_overrun", 32'(overrun), 32'd0);

`ifdef MEM_TIMEOUT_EN
      // Stuck memory: watchdog aborts the read, output is the dry sample
      @(negedge clk);
      ready_mode = 2;
      record = 1'b0; loop = 1'b0; delay_reverb = 1'b0; delay_len = 16'd1;
      gain = 8'd255; sample_in = 16'd77; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 600) begin
         @(negedge clk);
         cyc++;
      end
      check("to_out_seen", 32'(out_valid), 32'd1);
      check("to_out", 32'(out_sample), 32'd77);
      check("to_flag", 32'(mem_timeout), 32'd1);
      check("to_idle", 32'(busy), 32'd0);
      wp = wp + 16'd1;
      ready_mode = 0;
`else
      check("to_tied", 32'(mem_timeout), 32'd0);
`endif

      // Randomized samples, wait states and mid-sequence config churn
      for (int i = 0; i < 40; i++) begin
         logic [15:0] dl;
         dl = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
         do_sample(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), dl,
                   8'($urandom_range(0, 12)), 8'($urandom), $urandom_range(0, 1), 1'b1, v);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
